rf_write_sched: RTL

Write-port scheduler for the 32×32 register file. It owns the file's single write port and sequences three sources onto it:
- a post-reset initialisation walk that loads r[i] = i;
- the core's writeback;
- a debug write requester driven from the board switches.

It also provides a slowly stepping scan address for the 7-segment register viewer, and applies the `sw_i[1]` write freeze centrally instead of inside the register file.

---
 rtl/rf_write_sched_if.sv | 32 +++
 rtl/rf_write_sched.sv | 126 ++++++++++++
 2 files changed

// File: rtl/rf_write_sched_if.sv
// Write-port bus between the core/debug/switch side and rf_write_sched.
// master = sources and viewer side; slave = the scheduler.
interface rf_write_sched_if #(
    parameter int NREG = 32,
    parameter int DW   = 32
);
    localparam int AW = $clog2(NREG);

    logic [15:0]   sw_i;
    logic          core_we;
    logic [AW-1:0] core_wa;
    logic [DW-1:0] core_wd;
    logic          dbg_req;
    logic [AW-1:0] dbg_wa;
    logic [DW-1:0] dbg_wd;
    logic          dbg_gnt;
    logic          init_busy;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;
    logic [AW-1:0] scan_ra;

    modport master (
        output sw_i, core_we, core_wa, core_wd, dbg_req, dbg_wa, dbg_wd,
        input  dbg_gnt, init_busy, rf_we, rf_wa, rf_wd, scan_ra
    );

    modport slave (
        input  sw_i, core_we, core_wa, core_wd, dbg_req, dbg_wa, dbg_wd,
        output dbg_gnt, init_busy, rf_we, rf_wa, rf_wd, scan_ra
    );
endinterface

// File: rtl/rf_write_sched.sv
// Register-file write-port scheduler: init walk, core writeback, debug writes, freeze and scan address.
// Optional init walk (r[i] = i after reset) enabled by defining RF_INIT_SEQ_EN.
module rf_write_sched #(
    parameter int NREG     = 32,
    parameter int DW       = 32,
    parameter int SCAN_DIV = 16
) (
    input  logic clk,
    input  logic rstn,
    rf_write_sched_if.slave bus
);
    localparam int AW   = $clog2(NREG);
    localparam int DIVW = $clog2(SCAN_DIV);

`ifdef RF_INIT_SEQ_EN
    typedef enum logic [1:0] {S_INIT, S_RUN, S_FROZEN} state_t;
    localparam state_t S_RESET = S_INIT;
`else
    typedef enum logic [1:0] {S_RUN, S_FROZEN} state_t;
    localparam state_t S_RESET = S_RUN;
`endif

    state_t        state, state_nxt;
    logic          sel_we, sel_gnt;
    logic [AW-1:0] sel_wa;
    logic [DW-1:0] sel_wd;
    logic [DIVW-1:0] div_cnt;
    logic          sw_unused;

    assign sw_unused = ^{bus.sw_i[15:3], bus.sw_i[0]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_RESET;
        else       state <= state_nxt;
    end

`ifdef RF_INIT_SEQ_EN
    logic [AW-1:0] walk_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            walk_cnt      <= AW'(1);
            bus.init_busy <= 1'b1;
        end else begin
            if (state == S_INIT) walk_cnt <= walk_cnt + AW'(1);
            // Lags the state by one cycle so busy covers the last walk write on the outputs
            bus.init_busy <= (state == S_INIT);
        end
    end
`else
    assign bus.init_busy = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
`ifdef RF_INIT_SEQ_EN
            S_INIT:   if (walk_cnt == AW'(NREG - 1)) state_nxt = S_RUN;
`endif
            S_RUN:    if (bus.sw_i[1])  state_nxt = S_FROZEN;
            S_FROZEN: if (!bus.sw_i[1]) state_nxt = S_RUN;
            default:  state_nxt = S_RESET;
        endcase
    end

    always_comb begin
        sel_we  = 1'b0;
        sel_gnt = 1'b0;
        sel_wa  = '0;
        sel_wd  = '0;
        case (state)
`ifdef RF_INIT_SEQ_EN
            S_INIT: begin
                sel_we = 1'b1;
                sel_wa = walk_cnt;
                sel_wd = DW'(walk_cnt);
            end
`endif
            S_RUN: begin
                // Freeze blocks selection in the very cycle it is sampled; a live grant
                // masks the request so a held dbg_req is not served twice
                if (!bus.sw_i[1]) begin
                    if (bus.core_we) begin
                        sel_we = 1'b1;
                        sel_wa = bus.core_wa;
                        sel_wd = bus.core_wd;
                    end else if (bus.dbg_req && !bus.dbg_gnt) begin
                        sel_we  = 1'b1;
                        sel_gnt = 1'b1;
                        sel_wa  = bus.dbg_wa;
                        sel_wd  = bus.dbg_wd;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.rf_we   <= 1'b0;
            bus.rf_wa   <= '0;
            bus.rf_wd   <= '0;
            bus.dbg_gnt <= 1'b0;
        end else begin
            bus.rf_we   <= sel_we && (sel_wa != '0);
            bus.rf_wa   <= sel_wa;
            bus.rf_wd   <= sel_wd;
            bus.dbg_gnt <= sel_gnt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt     <= '0;
            bus.scan_ra <= '0;
        end else if (bus.sw_i[2]) begin
            if (div_cnt == DIVW'(SCAN_DIV - 1)) begin
                div_cnt     <= '0;
                bus.scan_ra <= (bus.scan_ra == AW'(NREG - 1)) ? '0 : bus.scan_ra + AW'(1);
            end else begin
                div_cnt <= div_cnt + DIVW'(1);
            end
        end
    end
endmodule
